// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl
//   Scan sequencer sitting directly upstream of a 4:1 channel mux. It drives
//   the mux select, waits DWELL cycles for the mux output to settle, captures
//   the muxed value and presents it on a valid/ready stream tagged with its
//   channel. A per-channel snapshot register keeps the last captured value of
//   every channel. Channels are visited round-robin through the set bits of
//   ch_mask.
//
//   Optional feature (compile-time macro SCAN_CHANGE_DETECT_EN):
//     When defined, a capture whose value equals the channel's snapshot (and
//     the channel has been captured at least once since reset) is not emitted;
//     the sequencer advances immediately as if the sample had been accepted.
//     When undefined, every capture is emitted and no seen storage exists.
//
// Parameters
//   DW     data width of mux_out, sample_data and each snapshot entry
//   DWELL  cycles from a select change to the capture (>= 1)
//   CW     dwell counter width, derived from DWELL
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   enable        in   scan enable
//   ch_mask       in   [3:0] channel i scanned when bit i is set
//   mux_out       in   [DW-1:0] output of the 4:1 mux
//   select        out  [1:0] mux select (registered)
//   sample_valid  out  sample stream valid
//   sample_ready  in   sample stream ready
//   sample_ch     out  [1:0] channel of the current sample
//   sample_data   out  [DW-1:0] captured value
//   frame_done    out  one-cycle pulse when the last enabled channel of a
//                      pass has been handed off
//   snapshot      out  [4*DW-1:0] last capture per channel, ch i at [i*DW +: DW]
// ---------------------------------------------------------------------------
module mux_scan_ctrl #(
  parameter int DW    = 4,
  parameter int DWELL = 3,
  parameter int CW    = $clog2(DWELL + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [3:0]      ch_mask,
  input  logic [DW-1:0]   mux_out,
  output logic [1:0]      select,
  output logic            sample_valid,
  input  logic            sample_ready,
  output logic [1:0]      sample_ch,
  output logic [DW-1:0]   sample_data,
  output logic            frame_done,
  output logic [4*DW-1:0] snapshot
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  state_t          state;
  logic [CW-1:0]   counter;

  logic            mask_nz;
  logic            pass_end;
  logic [1:0]      first_ch;
  logic [1:0]      next_sel;
  logic [DW-1:0]   cur_snap;

`ifdef SCAN_CHANGE_DETECT_EN
  logic [3:0]      seen;
`endif

  // Lowest set bit of the mask; 0 when the mask is empty (caller guards).
  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Next set bit strictly above cur, wrapping past 3 to the lowest set bit.
  // The circular search cur+1, cur+2, cur+3 gives exactly that order; if no
  // other bit is set the current channel is rescanned.
  function automatic logic [1:0] next_ch(input logic [3:0] m,
                                         input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] c;
    r = cur;
    for (int k = 3; k >= 1; k--) begin
      c = cur + 2'(k);
      if (m[c]) r = c;
    end
    return r;
  endfunction

  // True when cur closes a pass: it is the highest set bit of the mask, or
  // it has been removed from the mask while in flight.
  function automatic logic closes_pass(input logic [3:0] m,
                                       input logic [1:0] cur);
    logic last;
    last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > int'(cur) && m[i]) last = 1'b0;
    end
    return last || !m[cur];
  endfunction

  always_comb begin
    mask_nz  = |ch_mask;
    pass_end = closes_pass(ch_mask, select);
    first_ch = lowest_ch(ch_mask);
    next_sel = next_ch(ch_mask, select);
    cur_snap = snapshot[select*DW +: DW];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      select       <= 2'd0;
      sample_valid <= 1'b0;
      sample_ch    <= 2'd0;
      sample_data  <= '0;
      frame_done   <= 1'b0;
      snapshot     <= '0;
`ifdef SCAN_CHANGE_DETECT_EN
      seen         <= 4'd0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        // ---- idle: wait for a scan request ----
        IDLE: begin
          if (enable && mask_nz) begin
            select  <= first_ch;
            counter <= '0;
            state   <= SETTLE;
          end
        end

        // ---- settle: let the mux output stabilise, then capture ----
        SETTLE: begin
          if (!enable) begin
            // Abort without touching the sample or the snapshot.
            state <= IDLE;
          end else if (counter == LAST_CNT) begin
            snapshot[select*DW +: DW] <= mux_out;
`ifdef SCAN_CHANGE_DETECT_EN
            if (seen[select] && mux_out == cur_snap) begin
              // Unchanged value: skip the stream and advance right away.
              frame_done <= pass_end;
              if (!mask_nz) begin
                state <= IDLE;
              end else begin
                select  <= next_sel;
                counter <= '0;
                state   <= SETTLE;
              end
            end else begin
              seen[select] <= 1'b1;
              sample_data  <= mux_out;
              sample_ch    <= select;
              sample_valid <= 1'b1;
              state        <= EMIT;
            end
`else
            sample_data  <= mux_out;
            sample_ch    <= select;
            sample_valid <= 1'b1;
            state        <= EMIT;
`endif
          end else begin
            counter <= counter + CW'(1);
          end
        end

        // ---- emit: hold the sample until it is accepted ----
        EMIT: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            frame_done   <= pass_end;
            if (!enable || !mask_nz) begin
              state <= IDLE;
            end else begin
              select  <= next_sel;
              counter <= '0;
              state   <= SETTLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_ctrl
//   Directed bench for mux_scan_ctrl (DW=4, DWELL=3). A behavioural 4:1 mux
//   feeds mux_out from a small table indexed by the DUT's select output.
//   Build with SCAN_CHANGE_DETECT_EN defined to exercise the change-detect
//   sequence instead of the plain scan sequence.
// ---------------------------------------------------------------------------
module tb_mux_scan_ctrl;

  localparam int DW = 4;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [3:0]      ch_mask;
  logic [DW-1:0]   mux_out;
  logic [1:0]      select;
  logic            sample_valid;
  logic            sample_ready;
  logic [1:0]      sample_ch;
  logic [DW-1:0]   sample_data;
  logic            frame_done;
  logic [4*DW-1:0] snapshot;

  logic [DW-1:0]   in_v [4];

  int total = 0;
  int bad   = 0;

  mux_scan_ctrl #(.DW(DW), .DWELL(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .mux_out      (mux_out),
    .select       (select),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data),
    .frame_done   (frame_done),
    .snapshot     (snapshot)
  );

  assign mux_out = in_v[select];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until sample_valid is seen (bounded). n = edges taken,
  // fds = frame_done pulses observed along the way.
  task automatic wait_valid(input int max, output int n, output int fds);
    n   = 0;
    fds = 0;
    do begin
      tick();
      n++;
      if (frame_done) fds++;
    end while (!sample_valid && n < max);
  endtask

  task automatic chk_sample(input string tag, input int n, input int fds,
                            input int exp_n, input int exp_fds,
                            input logic [1:0] ch, input logic [3:0] data);
    chk({tag, "_lat"},   n, exp_n);
    chk({tag, "_fd"},    fds, exp_fds);
    chk({tag, "_valid"}, sample_valid, 1'b1);
    chk({tag, "_ch"},    sample_ch, ch);
    chk({tag, "_data"},  sample_data, data);
    chk({tag, "_sel"},   select, ch);
  endtask

  initial begin
    int n;
    int fds;
    int vcnt;

    reset        = 1'b1;
    enable       = 1'b0;
    ch_mask      = 4'd0;
    sample_ready = 1'b0;
    in_v[0] = 4'd1;
    in_v[1] = 4'd2;
    in_v[2] = 4'd3;
    in_v[3] = 4'd4;

    tick();
    tick();
    chk("rst_select", select, 2'd0);
    chk("rst_valid",  sample_valid, 1'b0);
    chk("rst_ch",     sample_ch, 2'd0);
    chk("rst_data",   sample_data, 4'd0);
    chk("rst_fd",     frame_done, 1'b0);
    chk("rst_snap",   snapshot, 16'h0000);
    reset = 1'b0;
    tick();
    chk("idle_valid", sample_valid, 1'b0);

`ifndef SCAN_CHANGE_DETECT_EN
    // Full mask round-robin, one sample per 4 cycles.
    enable       = 1'b1;
    ch_mask      = 4'b1111;
    sample_ready = 1'b1;
    wait_valid(20, n, fds);
    chk_sample("t1_s0", n, fds, 4, 0, 2'd0, 4'd1);
    wait_valid(20, n, fds);
    chk_sample("t1_s1", n, fds, 4, 0, 2'd1, 4'd2);
    wait_valid(20, n, fds);
    chk_sample("t1_s2", n, fds, 4, 0, 2'd2, 4'd3);
    wait_valid(20, n, fds);
    chk_sample("t1_s3", n, fds, 4, 0, 2'd3, 4'd4);
    tick();
    chk("t1_fd",    frame_done, 1'b1);
    chk("t1_vlow",  sample_valid, 1'b0);
    chk("t1_wrap",  select, 2'd0);
    chk("t1_snap",  snapshot, 16'h4321);
    tick();
    chk("t1_fd_off", frame_done, 1'b0);

    // Mask 1010: in-flight ch0 completes, then 1,3,1,3.
    ch_mask = 4'b1010;
    wait_valid(20, n, fds);
    chk_sample("t2_inflight", n, fds, 2, 0, 2'd0, 4'd1);
    wait_valid(20, n, fds);
    chk_sample("t2_s1a", n, fds, 4, 1, 2'd1, 4'd2);
    wait_valid(20, n, fds);
    chk_sample("t2_s3a", n, fds, 4, 0, 2'd3, 4'd4);
    wait_valid(20, n, fds);
    chk_sample("t2_s1b", n, fds, 4, 1, 2'd1, 4'd2);
    wait_valid(20, n, fds);
    chk_sample("t2_s3b", n, fds, 4, 0, 2'd3, 4'd4);

    // Backpressure: hold ready low for 10 cycles in EMIT.
    sample_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_valid", sample_valid, 1'b1);
      chk("t3_hold_ch",    sample_ch, 2'd3);
      chk("t3_hold_data",  sample_data, 4'd4);
      chk("t3_hold_sel",   select, 2'd3);
    end
    sample_ready = 1'b1;
    tick();
    chk("t3_hs_valid", sample_valid, 1'b0);
    chk("t3_hs_fd",    frame_done, 1'b1);
    chk("t3_hs_sel",   select, 2'd1);
    wait_valid(20, n, fds);
    chk_sample("t3_next", n, fds, 3, 0, 2'd1, 4'd2);

    // Abort in SETTLE with counter==1; ch3 input changed but never captured.
    in_v[3] = 4'd9;
    tick();
    chk("t4_hs_sel", select, 2'd3);
    chk("t4_hs_fd",  frame_done, 1'b0);
    tick();
    enable = 1'b0;
    tick();
    chk("t4_valid", sample_valid, 1'b0);
    chk("t4_sel",   select, 2'd3);
    chk("t4_snap",  snapshot, 16'h4321);
    tick();
    tick();
    chk("t4_idle_valid", sample_valid, 1'b0);
    chk("t4_idle_sel",   select, 2'd3);
    chk("t4_idle_snap",  snapshot, 16'h4321);

    // Asynchronous reset in the middle of EMIT.
    ch_mask = 4'b1110;
    enable  = 1'b1;
    wait_valid(20, n, fds);
    chk_sample("t5_pre", n, fds, 4, 0, 2'd1, 4'd2);
    sample_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t5_select", select, 2'd0);
    chk("t5_valid",  sample_valid, 1'b0);
    chk("t5_ch",     sample_ch, 2'd0);
    chk("t5_data",   sample_data, 4'd0);
    chk("t5_fd",     frame_done, 1'b0);
    chk("t5_snap",   snapshot, 16'h0000);
    tick();
    reset        = 1'b0;
    sample_ready = 1'b1;
    wait_valid(20, n, fds);
    chk_sample("t5_restart", n, fds, 4, 0, 2'd1, 4'd2);
    chk("t5_snap_after", snapshot, 16'h0020);
`else
    // Change detect: first pass emits all four, then silence.
    enable       = 1'b1;
    ch_mask      = 4'b1111;
    sample_ready = 1'b1;
    wait_valid(20, n, fds);
    chk_sample("t6_s0", n, fds, 4, 0, 2'd0, 4'd1);
    wait_valid(20, n, fds);
    chk_sample("t6_s1", n, fds, 4, 0, 2'd1, 4'd2);
    wait_valid(20, n, fds);
    chk_sample("t6_s2", n, fds, 4, 0, 2'd2, 4'd3);
    wait_valid(20, n, fds);
    chk_sample("t6_s3", n, fds, 4, 0, 2'd3, 4'd4);
    tick();
    chk("t6_fd_first", frame_done, 1'b1);
    chk("t6_snap",     snapshot, 16'h4321);
    vcnt = 0;
    fds  = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (sample_valid) vcnt++;
      if (frame_done) fds++;
    end
    chk("t6_quiet_samples", vcnt, 0);
    chk("t6_quiet_fd",      fds, 2);
    in_v[2] = 4'd7;
    wait_valid(30, n, fds);
    chk_sample("t6_change", n, fds, 9, 0, 2'd2, 4'd7);
    chk("t6_snap_new", snapshot, 16'h4721);
    vcnt = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (sample_valid) vcnt++;
    end
    chk("t6_after_change", vcnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
